// File: rtl/sap_pkg.sv
// Shared types and constants for the SAP output display slice.
// Holds the converter FSM state type, seven-segment table and idle drive levels.
package sap_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } disp_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [2:0] AN_OFF  = 3'b111;

  // Active-low {g,f,e,d,c,b,a} patterns for digits 0..9.
  localparam logic [6:0] SEG7_LUT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // Nibbles above 9 cannot come from an 8-bit value; show them dark.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] r;
    if (n > 4'd9) r = SEG_OFF;
    else          r = SEG7_LUT[n];
    return r;
  endfunction

endpackage

// File: rtl/out_display_if.sv
// Output-port bundle: value/strobe in, segment/anode/busy out.
// master drives D/Upd and observes the display; slave is the driver block.
interface out_display_if;
  logic [7:0] D;
  logic       Upd;
  logic [6:0] Seg;
  logic [2:0] An;
  logic       Busy;

  modport master (
    output D, Upd,
    input  Seg, An, Busy
  );

  modport slave (
    input  D, Upd,
    output Seg, An, Busy
  );
endinterface

// File: rtl/out_bin2bcd.sv
// Sequential 8-bit to 3-digit BCD converter (shift-add-3, 8 iterations).
// Ports: CLK, CLR_, start, bin in; bcd, done (COMMIT cycle), busy out.
module out_bin2bcd
  import sap_pkg::*;
(
  input  logic        CLK,
  input  logic        CLR_,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic [11:0] bcd,
  output logic        done,
  output logic        busy
);

  disp_state_t state;
  logic [7:0]  sh;
  logic [11:0] acc;
  logic [11:0] adj;
  logic [2:0]  cnt;

  always_comb begin
    adj = acc;
    for (int i = 0; i < 3; i++) begin
      if (acc[i*4 +: 4] >= 4'd5)
        adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge CLK or negedge CLR_) begin
    if (!CLR_) begin
      state <= IDLE;
      sh    <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh    <= bin;
            acc   <= '0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc <= {adj[10:0], sh[7]};
          sh  <= {sh[6:0], 1'b0};
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) state <= COMMIT;
        end
        COMMIT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bcd  = acc;
  assign done = (state == COMMIT);
  assign busy = (state != IDLE);

endmodule

// File: rtl/out_display.sv
// Three-digit multiplexed seven-segment driver for the SAP output port.
// Ports: CLK, CLR_ (async low), bus (D/Upd in; Seg/An/Busy out).
module out_display
  import sap_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic          CLK,
  input  logic          CLR_,
  out_display_if.slave  bus
);

  localparam int PW = $clog2(SCAN_DIV);

  logic [PW-1:0]   presc;
  logic [1:0]      idx;
  logic [2:0][3:0] dig;
  logic            pend_v;
  logic [7:0]      pend_d;
  logic            start;
  logic [7:0]      bin;
  logic [11:0]     bcd;
  logic            done;
  logic            busy;
  logic [3:0]      cur;
  logic            blank;
  logic [6:0]      seg_n;
  logic [6:0]      seg_q;
  logic [2:0]      an_n;
  logic [2:0]      an_q;

  // Live value beats the buffered one when both are present.
  assign start = bus.Upd | pend_v;
  assign bin   = bus.Upd ? bus.D : pend_d;

  out_bin2bcd u_conv (
    .CLK   (CLK),
    .CLR_  (CLR_),
    .start (start),
    .bin   (bin),
    .bcd   (bcd),
    .done  (done),
    .busy  (busy)
  );

  // While idle any request is consumed at once, so the flag drops.
  always_ff @(posedge CLK or negedge CLR_) begin
    if (!CLR_) begin
      pend_v <= 1'b0;
      pend_d <= '0;
    end else if (busy) begin
      if (bus.Upd) begin
        pend_v <= 1'b1;
        pend_d <= bus.D;
      end
    end else begin
      pend_v <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge CLR_) begin
    if (!CLR_) dig <= '0;
    else if (done) dig <= bcd;
  end

  always_ff @(posedge CLK or negedge CLR_) begin
    if (!CLR_) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc <= '0;
      idx   <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_comb begin
    cur   = dig[0];
    blank = 1'b0;
    an_n  = 3'b110;
    case (idx)
      2'd1: begin
        cur   = dig[1];
        blank = BLANK_LZ && (dig[2] == 4'd0) && (dig[1] == 4'd0);
        an_n  = 3'b101;
      end
      2'd2: begin
        cur   = dig[2];
        blank = BLANK_LZ && (dig[2] == 4'd0);
        an_n  = 3'b011;
      end
      default: ;
    endcase
    seg_n = seg7(cur);
    if (blank) begin
      seg_n = SEG_OFF;
      an_n  = AN_OFF;
    end
  end

  always_ff @(posedge CLK or negedge CLR_) begin
    if (!CLR_) begin
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
    end else begin
      seg_q <= seg_n;
      an_q  <= an_n;
    end
  end

  assign bus.Seg  = seg_q;
  assign bus.An   = an_q;
  assign bus.Busy = busy;

endmodule
